// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit engine: FIFO fetch, framing, parity, sent-byte count
// Optional second stop bit when TX_TWO_STOPBIT_EN is defined (adds p_TwoStop_i).
module uart_tx_engine #(
  parameter int BYTE_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data_i,
  input  logic                  p_empty_i,
  output logic                  n_rd_o,
  input  logic                  BaudSig_i,
  input  logic                  p_ParityEnable_i,
  input  logic                  ParityMethod_i,
  input  logic                  p_BigEnd_i,
`ifdef TX_TWO_STOPBIT_EN
  input  logic                  p_TwoStop_i,
`endif
  output logic [4:0]            State_o,
  output logic                  p_DataSent_o,
  output logic [BYTE_CNT_W-1:0] TxByteNum_o,
  output logic                  p_Busy_o,
  output logic                  Tx_o
);

  typedef enum logic [4:0] {
    INTERVAL  = 5'b00001,
    STARTBIT  = 5'b00010,
    DATABITS  = 5'b00100,
    PARITYBIT = 5'b01000,
    STOPBIT   = 5'b10000
  } state_t;

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_STROBE = 2'd1,
    FETCH_GRAB   = 2'd2
  } fetch_t;

  state_t     state;
  fetch_t     fetch_ph;
  logic       held;
  logic [7:0] data_q;
  logic       par_en_q;
  logic       par_odd_q;
  logic       big_end_q;
  logic       two_stop_q;
  logic       stop_second;
  logic [3:0] bit_cnt;
  logic       two_stop_in;
  logic       par_bit;

`ifdef TX_TWO_STOPBIT_EN
  assign two_stop_in = p_TwoStop_i;
`else
  assign two_stop_in = 1'b0;
`endif

  assign par_bit  = (^data_q) ^ par_odd_q;
  assign State_o  = state;
  assign p_Busy_o = (state != INTERVAL) || held;

  function automatic logic data_bit(input logic [7:0] d, input logic big, input logic [2:0] idx);
    return big ? d[3'd7 - idx] : d[idx];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= INTERVAL;
      fetch_ph     <= FETCH_IDLE;
      held         <= 1'b0;
      data_q       <= 8'h00;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      big_end_q    <= 1'b0;
      two_stop_q   <= 1'b0;
      stop_second  <= 1'b0;
      bit_cnt      <= 4'd0;
      n_rd_o       <= 1'b1;
      p_DataSent_o <= 1'b0;
      TxByteNum_o  <= '0;
      Tx_o         <= 1'b1;
    end else begin
      p_DataSent_o <= 1'b0;
      n_rd_o       <= 1'b1;

      // FIFO data is valid one clk after the strobe, so capture happens two clks after issue
      unique case (fetch_ph)
        FETCH_IDLE: begin
          if (state == INTERVAL && !held && !p_empty_i) begin
            n_rd_o   <= 1'b0;
            fetch_ph <= FETCH_STROBE;
          end
        end
        FETCH_STROBE: fetch_ph <= FETCH_GRAB;
        default: begin
          data_q     <= data_i;
          par_en_q   <= p_ParityEnable_i;
          par_odd_q  <= ParityMethod_i;
          big_end_q  <= p_BigEnd_i;
          two_stop_q <= two_stop_in;
          held       <= 1'b1;
          fetch_ph   <= FETCH_IDLE;
        end
      endcase

      if (BaudSig_i) begin
        unique case (state)
          INTERVAL: begin
            if (held) begin
              state   <= STARTBIT;
              bit_cnt <= 4'd0;
              Tx_o    <= 1'b0;
            end
          end
          STARTBIT: begin
            state <= DATABITS;
            Tx_o  <= data_bit(data_q, big_end_q, 3'd0);
          end
          DATABITS: begin
            if (bit_cnt == 4'd7) begin
              if (par_en_q) begin
                state <= PARITYBIT;
                Tx_o  <= par_bit;
              end else begin
                state       <= STOPBIT;
                Tx_o        <= 1'b1;
                stop_second <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              Tx_o    <= data_bit(data_q, big_end_q, bit_cnt[2:0] + 3'd1);
            end
          end
          PARITYBIT: begin
            state       <= STOPBIT;
            Tx_o        <= 1'b1;
            stop_second <= 1'b0;
          end
          STOPBIT: begin
            if (two_stop_q && !stop_second) begin
              stop_second <= 1'b1;
            end else begin
              state        <= INTERVAL;
              Tx_o         <= 1'b1;
              p_DataSent_o <= 1'b1;
              TxByteNum_o  <= TxByteNum_o + {{(BYTE_CNT_W-1){1'b0}}, 1'b1};
              held         <= 1'b0;
            end
          end
          default: begin
            state <= INTERVAL;
            Tx_o  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
